// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CW_DEF  = 32;
  localparam int CW_MAX  = 64;
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [CW_MAX-1:0] div;
    logic [CW_MAX-1:0] high;
  } cfg_pair_t;

  // Force a usable (period, high) pair: period at least two cycles, high never beyond the period
  function automatic cfg_pair_t clamp_cfg(input logic [CW_MAX-1:0] div,
                                          input logic [CW_MAX-1:0] high);
    cfg_pair_t r;
    r.div  = (div < CW_MAX'(MIN_DIV)) ? CW_MAX'(MIN_DIV) : div;
    r.high = (high > r.div) ? r.div : high;
    return r;
  endfunction

endpackage

// File: rtl/multi_clk_div_if.sv
// Configuration request channel shared by the requester and the divider block.
interface multi_clk_div_if #(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
);

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [CW-1:0]  cfg_high;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready);

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active config, one-deep pending config slot and registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CW       = CW_DEF,
  parameter int unsigned DEF_DIV  = 100000000,
  parameter int unsigned DEF_HIGH = 50000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          acc,
  input  logic [CW-1:0] acc_div,
  input  logic [CW-1:0] acc_high,
  output logic          pend,
  output logic          clkout,
  output logic          tick,
  output logic [CW-1:0] cnt
);

  localparam cfg_pair_t     DEF_CFG  = clamp_cfg(CW_MAX'(DEF_DIV), CW_MAX'(DEF_HIGH));
  localparam logic [CW-1:0] RST_DIV  = CW'(DEF_CFG.div);
  localparam logic [CW-1:0] RST_HIGH = CW'(DEF_CFG.high);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] pdiv_q, pdiv_d;
  logic [CW-1:0] phigh_q, phigh_d;
  logic          pend_q, pend_d;
  logic          clkout_q, clkout_d;
  logic          tick_q, tick_d;

  logic          wrap;
  cfg_pair_t     acc_cfg;

  assign wrap    = (cnt_q == div_q - CW'(1));
  assign acc_cfg = clamp_cfg(CW_MAX'(acc_div), CW_MAX'(acc_high));

  if (CW < CW_MAX) begin : g_hi_sink
    logic unused_hi;
    assign unused_hi = ^{acc_cfg.div[CW_MAX-1:CW], acc_cfg.high[CW_MAX-1:CW]};
  end

  // Count, generate outputs from the pre-edge count, swap in pending config at a period boundary
  always_comb begin
    cnt_d    = '0;
    div_d    = div_q;
    high_d   = high_q;
    pdiv_d   = pdiv_q;
    phigh_d  = phigh_q;
    pend_d   = pend_q;
    clkout_d = 1'b0;
    tick_d   = 1'b0;
    if (en) begin
      clkout_d = (cnt_q < high_q);
      tick_d   = wrap;
      cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    end
    if (pend_q && (!en || wrap)) begin
      div_d  = pdiv_q;
      high_d = phigh_q;
      pend_d = 1'b0;
    end
    if (acc && !pend_q) begin
      pend_d  = 1'b1;
      pdiv_d  = CW'(acc_cfg.div);
      phigh_d = CW'(acc_cfg.high);
    end
  end

  // Channel state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      div_q    <= RST_DIV;
      high_q   <= RST_HIGH;
      pdiv_q   <= RST_DIV;
      phigh_q  <= RST_HIGH;
      pend_q   <= 1'b0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      high_q   <= high_d;
      pdiv_q   <= pdiv_d;
      phigh_q  <= phigh_d;
      pend_q   <= pend_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

  assign pend   = pend_q;
  assign clkout = clkout_q;
  assign tick   = tick_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/multi_clk_div.sv
// N-channel programmable clock divider; the top only decodes config requests onto the channels.
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          CW       = CW_DEF,
  parameter int unsigned DEF_DIV  = 100000000,
  parameter int unsigned DEF_HIGH = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  multi_clk_div_if.slave    cfg,
  output logic [NCH-1:0]    clkout,
  output logic [NCH-1:0]    tick,
  output logic [NCH*CW-1:0] counter
);

  logic [NCH-1:0] pend_vec;
  logic [NCH-1:0] acc_vec;
  logic           ready;

  // Route the request to its channel; out-of-range channels are never ready
  always_comb begin
    ready   = 1'b0;
    acc_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(cfg.cfg_ch) == i) begin
        ready      = ~pend_vec[i];
        acc_vec[i] = cfg.cfg_valid & ~pend_vec[i];
      end
    end
  end

  assign cfg.cfg_ready = ready;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CW       (CW),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[g]),
      .acc      (acc_vec[g]),
      .acc_div  (cfg.cfg_div),
      .acc_high (cfg.cfg_high),
      .pend     (pend_vec[g]),
      .clkout   (clkout[g]),
      .tick     (tick[g]),
      .cnt      (counter[g*CW +: CW])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div with a small period-level reference model.
module tb_multi_clk_div;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    en;
  logic [3:0]    clkout;
  logic [3:0]    tick;
  logic [31:0]   counter;

  multi_clk_div_if #(.NCH(NCH), .CW(CW)) cfg_if ();

  multi_clk_div #(
    .NCH(NCH), .CW(CW), .DEF_DIV(10), .DEF_HIGH(5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cfg     (cfg_if),
    .clkout  (clkout),
    .tick    (tick),
    .counter (counter)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: where each channel sits in its period, the period shape, and a pending request
  int         m_pos   [4];
  int         m_div   [4];
  int         m_high  [4];
  int         m_pdiv  [4];
  int         m_phigh [4];
  bit         m_pend  [4];
  logic [3:0] m_clk;
  logic [3:0] m_tick;

  int obs_ticks [4];
  int obs_high  [4];
  bit last_accept;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void clamp(input int d, input int h, output int cd, output int ch);
    cd = (d < 2) ? 2 : d;
    ch = (h > cd) ? cd : h;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_pos[c]  = 0;
      clamp(10, 5, m_div[c], m_high[c]);
      m_pdiv[c] = 0;
      m_phigh[c] = 0;
      m_pend[c] = 1'b0;
    end
    m_clk  = '0;
    m_tick = '0;
  endfunction

  function automatic void model_step(input logic [3:0] e, input bit v, input int ch,
                                     input int d, input int h);
    bit last_of_period;
    bit had_pend;
    for (int c = 0; c < 4; c++) begin
      last_of_period = (m_pos[c] == m_div[c] - 1);
      had_pend       = m_pend[c];
      if (e[c]) begin
        m_clk[c]  = (m_pos[c] < m_high[c]);
        m_tick[c] = last_of_period;
        m_pos[c]  = (m_pos[c] + 1) % m_div[c];
      end else begin
        m_clk[c]  = 1'b0;
        m_tick[c] = 1'b0;
        m_pos[c]  = 0;
      end
      if (had_pend && (!e[c] || last_of_period)) begin
        m_div[c]  = m_pdiv[c];
        m_high[c] = m_phigh[c];
        m_pend[c] = 1'b0;
      end
      if (v && ch == c && !had_pend) begin
        m_pend[c] = 1'b1;
        clamp(d, h, m_pdiv[c], m_phigh[c]);
      end
    end
  endfunction

  function automatic void clear_obs();
    for (int c = 0; c < 4; c++) begin
      obs_ticks[c] = 0;
      obs_high[c]  = 0;
    end
  endfunction

  task automatic applyStimulus();
    logic [3:0]  e;
    bit          v;
    int          ch;
    int          d;
    int          h;
    bit          exp_ready;
    logic [31:0] exp_counter;
    #2;
    exp_ready = !m_pend[cfg_if.cfg_ch];
    check("cfg_ready", 64'(cfg_if.cfg_ready), 64'(exp_ready));
    e  = en;
    v  = cfg_if.cfg_valid;
    ch = int'(cfg_if.cfg_ch);
    d  = int'(cfg_if.cfg_div);
    h  = int'(cfg_if.cfg_high);
    last_accept = v && exp_ready;
    @(posedge clk);
    model_step(e, v, ch, d, h);
    #1;
    for (int c = 0; c < 4; c++) begin
      exp_counter[c*8 +: 8] = 8'(m_pos[c]);
      obs_ticks[c] += int'(tick[c]);
      obs_high[c]  += int'(clkout[c]);
    end
    check("counter", 64'(counter), 64'(exp_counter));
    check("clkout", 64'(clkout), 64'(m_clk));
    check("tick", 64'(tick), 64'(m_tick));
  endtask

  task automatic run(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic cfg_load(input int ch, input int d, input int h, output int waited);
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = 8'(d);
    cfg_if.cfg_high  = 8'(h);
    cfg_if.cfg_valid = 1'b1;
    waited = 0;
    forever begin
      applyStimulus();
      if (last_accept || waited >= 100) break;
      waited++;
    end
    check("cfg_accept", 64'(last_accept), 64'(1));
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int ch, input int val);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus();
      found = (counter[ch*8 +: 8] == 8'(val));
    end
    check("wait_cnt", 64'(found), 64'(1));
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_cnt,
                             input logic [3:0] exp_clk, input logic [3:0] exp_tick);
    check({tag, "_counter"}, 64'(counter), 64'(exp_cnt));
    check({tag, "_clkout"}, 64'(clkout), 64'(exp_clk));
    check({tag, "_tick"}, 64'(tick), 64'(exp_tick));
  endtask

  initial begin
    int w;
    rst = 1'b0;
    en  = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_high  = '0;
    model_reset();
    clear_obs();
    #12;
    checkOutput("reset", '0, '0, '0);
    check("reset_ready", 64'(cfg_if.cfg_ready), 64'(1));
    @(negedge clk);
    rst = 1'b1;

    // 1: ch0 alone at the default 10/5
    en = 4'b0001;
    clear_obs();
    run(30);
    check("t1_ticks", 64'(obs_ticks[0]), 64'(3));
    check("t1_high", 64'(obs_high[0]), 64'(15));
    check("t1_others", 64'(obs_ticks[1] + obs_ticks[2] + obs_ticks[3]), 64'(0));

    // 2: mid-period load waits for the wrap
    wait_cnt(0, 3);
    cfg_load(0, 4, 1, w);
    run(20);

    // 3: clamping to 2/2 then 6/0
    cfg_load(0, 0, 7, w);
    run(12);
    clear_obs();
    run(10);
    check("t3_stuck_high", 64'(obs_high[0]), 64'(10));
    cfg_load(0, 6, 0, w);
    run(12);
    clear_obs();
    run(12);
    check("t3_ticks6", 64'(obs_ticks[0]), 64'(2));
    check("t3_stuck_low", 64'(obs_high[0]), 64'(0));

    // 4: second ch1 load stalls, ch2 load goes straight in
    en = 4'b0011;
    cfg_load(1, 7, 3, w);
    cfg_if.cfg_ch    = 2'd1;
    cfg_if.cfg_div   = 8'd5;
    cfg_if.cfg_high  = 8'd2;
    cfg_if.cfg_valid = 1'b1;
    applyStimulus();
    check("t4_stall", 64'(last_accept), 64'(0));
    cfg_load(2, 3, 1, w);
    check("t4_ch2_imm", 64'(w), 64'(0));
    cfg_load(1, 5, 2, w);
    check("t4_ch1_waited", 64'(w > 0), 64'(1));
    run(25);

    // 5: disable mid-period with a pending load, then restart
    en = 4'b0111;
    run(12);
    wait_cnt(1, 1);
    cfg_load(1, 9, 4, w);
    en[1] = 1'b0;
    applyStimulus();
    check("t5_cnt_zero", 64'(counter[15:8]), 64'(0));
    check("t5_clk_zero", 64'(clkout[1]), 64'(0));
    cfg_if.cfg_ch = 2'd1;
    run(3);
    check("t5_slot_free", 64'(cfg_if.cfg_ready), 64'(1));
    en[1] = 1'b1;
    clear_obs();
    run(9);
    check("t5_first_ticks", 64'(obs_ticks[1]), 64'(1));
    check("t5_first_high", 64'(obs_high[1]), 64'(4));

    // 6: asynchronous reset between edges
    en = 4'b1111;
    run(5);
    wait_cnt(0, 1);
    cfg_load(0, 8, 3, w);
    run(1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst", '0, '0, '0);
    cfg_if.cfg_ch = 2'd0;
    #1;
    check("async_rst_ready", 64'(cfg_if.cfg_ready), 64'(1));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    run(30);
    for (int c = 0; c < 4; c++) begin
      check("t6_ticks", 64'(obs_ticks[c]), 64'(3));
      check("t6_high", 64'(obs_high[c]), 64'(15));
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) en = 4'($urandom);
      cfg_if.cfg_valid = 1'($urandom);
      cfg_if.cfg_ch    = 2'($urandom);
      cfg_if.cfg_div   = 8'($urandom_range(0, 12));
      cfg_if.cfg_high  = 8'($urandom_range(0, 14));
      applyStimulus();
    end
    cfg_if.cfg_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
